// File: rtl/fpu_pkg.sv
// Shared opcodes, flag indices, IEEE-754 double field constants and the
// round-to-nearest-even packer used by the arithmetic units.
package fpu_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_MUL = 3'b010;
  localparam logic [2:0] OP_DIV = 3'b011;
  localparam logic [2:0] OP_NEG = 3'b100;
  localparam logic [2:0] OP_ABS = 3'b101;

  localparam int FLG_ZERO = 0;
  localparam int FLG_INF  = 1;
  localparam int FLG_NAN  = 2;
  localparam int FLG_ILL  = 3;

  localparam int          EXP_MSB  = 62;
  localparam int          EXP_LSB  = 52;
  localparam logic [10:0] EXP_ALL1 = 11'h7FF;

  localparam logic [63:0] FP_QNAN = 64'h7FF8_0000_0000_0000;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // n[55] is the leading one, n[2:0] are guard/round/sticky; exp is biased.
  function automatic logic [63:0] fp_pack(input logic sign,
                                          input logic signed [13:0] exp,
                                          input logic [55:0] n);
    logic [53:0]        r;
    logic               inc;
    logic signed [13:0] e;
    logic [51:0]        frac;
    inc  = n[2] & (n[1] | n[0] | n[3]);
    r    = {1'b0, n[55:3]} + {53'd0, inc};
    e    = exp;
    frac = r[51:0];
    if (r[53]) begin
      e    = e + 14'sd1;
      frac = r[52:1];
    end
    if (e <= 14'sd0)
      fp_pack = {sign, 63'd0};
    else if (e >= 14'sd2047)
      fp_pack = {sign, EXP_ALL1, 52'd0};
    else
      fp_pack = {sign, e[10:0], frac};
  endfunction

endpackage

// File: rtl/fp_adder.sv
// Combinational double adder, round-to-nearest-even; subnormal inputs and
// results are flushed to zero.
module fp_adder
  import fpu_pkg::*;
(
  input  logic [63:0] a,
  input  logic [63:0] b,
  output logic [63:0] result
);
  function automatic logic [5:0] lzc56(input logic [55:0] v);
    lzc56 = 6'd0;
    for (int i = 0; i < 56; i++)
      if (v[i]) lzc56 = 6'(55 - i);
  endfunction

  logic               a_nan, b_nan, a_inf, b_inf, swap, sl, ss, eff_sub;
  logic [10:0]        el, es;
  logic [52:0]        ml, ms;
  logic [11:0]        d;
  logic [55:0]        xs, xs_sh, n;
  logic [56:0]        sum;
  logic [5:0]         lz;
  logic signed [13:0] e;

  always_comb begin
    a_nan = (a[EXP_MSB:EXP_LSB] == EXP_ALL1) && (a[51:0] != 52'd0);
    b_nan = (b[EXP_MSB:EXP_LSB] == EXP_ALL1) && (b[51:0] != 52'd0);
    a_inf = (a[EXP_MSB:EXP_LSB] == EXP_ALL1) && (a[51:0] == 52'd0);
    b_inf = (b[EXP_MSB:EXP_LSB] == EXP_ALL1) && (b[51:0] == 52'd0);
    // larger magnitude goes to the "l" side so the difference never goes negative
    swap     = b[62:0] > a[62:0];
    {sl, el} = swap ? {b[63], b[62:52]} : {a[63], a[62:52]};
    {ss, es} = swap ? {a[63], a[62:52]} : {b[63], b[62:52]};
    ml = (el == 11'd0) ? 53'd0 : {1'b1, (swap ? b[51:0] : a[51:0])};
    ms = (es == 11'd0) ? 53'd0 : {1'b1, (swap ? a[51:0] : b[51:0])};
    d  = {1'b0, el} - {1'b0, es};
    xs = {ms, 3'b000};
    if (d > 12'd55)
      xs_sh = {55'd0, |xs};
    else
      xs_sh = (xs >> d[5:0]) | {55'd0, |(xs & ~({56{1'b1}} << d[5:0]))};
    eff_sub = sl ^ ss;
    sum = eff_sub ? ({1'b0, ml, 3'b000} - {1'b0, xs_sh})
                  : ({1'b0, ml, 3'b000} + {1'b0, xs_sh});
    lz = lzc56(sum[55:0]);
    if (sum[56]) begin
      n = {sum[56:2], |sum[1:0]};
      e = 14'(el) + 14'sd1;
    end else begin
      n = sum[55:0] << lz;
      e = 14'(el) - 14'(lz);
    end
    if (a_nan || b_nan || (a_inf && b_inf && eff_sub))
      result = FP_QNAN;
    else if (a_inf)
      result = a;
    else if (b_inf)
      result = b;
    else if (sum == 57'd0)
      result = {sl & ~eff_sub, 63'd0};
    else
      result = fp_pack(sl, e, n);
  end

endmodule

// File: rtl/fp_divider.sv
// Combinational double divider, round-to-nearest-even, subnormals flushed.
module fp_divider
  import fpu_pkg::*;
(
  input  logic [63:0] a,
  input  logic [63:0] b,
  output logic [63:0] result
);
  logic               a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, sign, rem_nz;
  logic [107:0]       num, den;
  logic [55:0]        q, n;
  logic signed [13:0] e;

  always_comb begin
    a_nan  = (a[EXP_MSB:EXP_LSB] == EXP_ALL1) && (a[51:0] != 52'd0);
    b_nan  = (b[EXP_MSB:EXP_LSB] == EXP_ALL1) && (b[51:0] != 52'd0);
    a_inf  = (a[EXP_MSB:EXP_LSB] == EXP_ALL1) && (a[51:0] == 52'd0);
    b_inf  = (b[EXP_MSB:EXP_LSB] == EXP_ALL1) && (b[51:0] == 52'd0);
    a_zero = a[EXP_MSB:EXP_LSB] == 11'd0;
    b_zero = b[EXP_MSB:EXP_LSB] == 11'd0;
    sign   = a[63] ^ b[63];
    // mantissa ratio lies in (0.5, 2): quotient carries 55 fraction bits
    num    = {1'b1, a[51:0], 55'd0};
    den    = {55'd0, 1'b1, b[51:0]};
    q      = 56'(num / den);
    rem_nz = (num % den) != 108'd0;
    e = 14'(a[62:52]) - 14'(b[62:52]) + 14'd1023 - (q[55] ? 14'd0 : 14'd1);
    n = q[55] ? {q[55:1], q[0] | rem_nz} : {q[54:0], rem_nz};
    if (a_nan || b_nan || (a_inf && b_inf) || (a_zero && b_zero))
      result = FP_QNAN;
    else if (a_inf || b_zero)
      result = {sign, EXP_ALL1, 52'd0};
    else if (b_inf || a_zero)
      result = {sign, 63'd0};
    else
      result = fp_pack(sign, e, n);
  end

endmodule

// File: rtl/fp_multiplier.sv
// Combinational double multiplier, round-to-nearest-even, subnormals flushed.
module fp_multiplier
  import fpu_pkg::*;
(
  input  logic [63:0] a,
  input  logic [63:0] b,
  output logic [63:0] result
);
  logic               a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, sign;
  logic [105:0]       p;
  logic [55:0]        n;
  logic signed [13:0] e;

  always_comb begin
    a_nan  = (a[EXP_MSB:EXP_LSB] == EXP_ALL1) && (a[51:0] != 52'd0);
    b_nan  = (b[EXP_MSB:EXP_LSB] == EXP_ALL1) && (b[51:0] != 52'd0);
    a_inf  = (a[EXP_MSB:EXP_LSB] == EXP_ALL1) && (a[51:0] == 52'd0);
    b_inf  = (b[EXP_MSB:EXP_LSB] == EXP_ALL1) && (b[51:0] == 52'd0);
    a_zero = a[EXP_MSB:EXP_LSB] == 11'd0;
    b_zero = b[EXP_MSB:EXP_LSB] == 11'd0;
    sign   = a[63] ^ b[63];
    p = 106'({1'b1, a[51:0]}) * 106'({1'b1, b[51:0]});
    e = 14'(a[62:52]) + 14'(b[62:52]) - 14'd1023 + (p[105] ? 14'd1 : 14'd0);
    n = p[105] ? {p[105:51], |p[50:0]} : {p[104:50], |p[49:0]};
    if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero))
      result = FP_QNAN;
    else if (a_inf || b_inf)
      result = {sign, EXP_ALL1, 52'd0};
    else if (a_zero || b_zero)
      result = {sign, 63'd0};
    else
      result = fp_pack(sign, e, n);
  end

endmodule

// File: rtl/fp_subtractor.sv
// Combinational double subtractor: a + (-b) through the adder.
module fp_subtractor (
  input  logic [63:0] a,
  input  logic [63:0] b,
  output logic [63:0] result
);
  fp_adder u_add (
    .a      (a),
    .b      ({~b[63], b[62:0]}),
    .result (result)
  );

endmodule

// File: rtl/fpu_result_classify.sv
// Classifies a double as NaN, infinity or zero (either sign).
module fpu_result_classify
  import fpu_pkg::*;
(
  input  logic [63:0] value,
  output logic        nan,
  output logic        inf,
  output logic        zero
);
  logic exp_ones, exp_zero, man_zero;
  logic unused_sign;

  assign exp_ones    = value[EXP_MSB:EXP_LSB] == EXP_ALL1;
  assign exp_zero    = value[EXP_MSB:EXP_LSB] == 11'd0;
  assign man_zero    = value[EXP_LSB-1:0] == 52'd0;
  assign nan         = exp_ones && !man_zero;
  assign inf         = exp_ones && man_zero;
  assign zero        = exp_zero && man_zero;
  assign unused_sign = value[63];

endmodule

// File: rtl/fpu_seq_unit.sv
// Handshaked double FPU sequencer: one operation in flight, fixed per-op
// latency, tagged result with {illegal, nan, inf, zero} flags.
module fpu_seq_unit
  import fpu_pkg::*;
#(
  parameter int TAG_W   = 4,
  parameter int ADD_LAT = 2,
  parameter int MUL_LAT = 3,
  parameter int DIV_LAT = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [63:0]      in_a,
  input  logic [63:0]      in_b,
  input  logic [2:0]       in_op,
  input  logic [TAG_W-1:0] in_tag,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [63:0]      out_result,
  output logic [TAG_W-1:0] out_tag,
  output logic [3:0]       out_flags
);
  // state | meaning
  // IDLE  | nothing held, ready for a request
  // BUSY  | operands registered, latency counter running
  // DONE  | result held on out_*, waiting for out_ready

  localparam int MAX_AM  = (ADD_LAT > MUL_LAT) ? ADD_LAT : MUL_LAT;
  localparam int MAX_LAT = (DIV_LAT > MAX_AM) ? DIV_LAT : MAX_AM;
  localparam int CNT_W   = (MAX_LAT > 2) ? $clog2(MAX_LAT) : 1;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic [63:0]        opr_a, opr_b;
  logic [2:0]         opr_op;
  logic [TAG_W-1:0]   opr_tag;
  logic               accept, capture, drop;
  logic [63:0]        add_res, sub_res, mul_res, div_res, sel_res;
  logic               res_nan, res_inf, res_zero, res_ill;

  function automatic logic [CNT_W-1:0] lat_m1(input logic [2:0] op);
    case (op)
      OP_ADD, OP_SUB: lat_m1 = CNT_W'(ADD_LAT - 1);
      OP_MUL:         lat_m1 = CNT_W'(MUL_LAT - 1);
      OP_DIV:         lat_m1 = CNT_W'(DIV_LAT - 1);
      default:        lat_m1 = '0;
    endcase
  endfunction

  assign in_ready = !flush && ((state == S_IDLE) || (state == S_DONE && out_ready));
  assign accept   = in_valid && in_ready;

  fp_adder      u_add (.a(opr_a), .b(opr_b), .result(add_res));
  fp_subtractor u_sub (.a(opr_a), .b(opr_b), .result(sub_res));
  fp_multiplier u_mul (.a(opr_a), .b(opr_b), .result(mul_res));
  fp_divider    u_div (.a(opr_a), .b(opr_b), .result(div_res));

  always_comb begin
    sel_res = 64'd0;
    res_ill = 1'b0;
    case (opr_op)
      OP_ADD:  sel_res = add_res;
      OP_SUB:  sel_res = sub_res;
      OP_MUL:  sel_res = mul_res;
      OP_DIV:  sel_res = div_res;
      OP_NEG:  sel_res = {~opr_a[63], opr_a[62:0]};
      OP_ABS:  sel_res = {1'b0, opr_a[62:0]};
      default: res_ill = 1'b1;
    endcase
  end

  fpu_result_classify u_cls (
    .value (sel_res),
    .nan   (res_nan),
    .inf   (res_inf),
    .zero  (res_zero)
  );

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    capture   = 1'b0;
    drop      = 1'b0;
    case (state)
      S_IDLE: begin
        if (accept) begin
          state_nxt = S_BUSY;
          cnt_nxt   = lat_m1(in_op);
        end
      end
      S_BUSY: begin
        if (flush) begin
          state_nxt = S_IDLE;
        end else if (cnt != '0) begin
          cnt_nxt = cnt - CNT_W'(1);
        end else begin
          capture   = 1'b1;
          state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        if (flush) begin
          drop      = 1'b1;
          state_nxt = S_IDLE;
        end else if (out_ready) begin
          // retire and accept on the same edge keeps the input side bubble-free
          drop = 1'b1;
          if (accept) begin
            state_nxt = S_BUSY;
            cnt_nxt   = lat_m1(in_op);
          end else begin
            state_nxt = S_IDLE;
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      cnt        <= '0;
      opr_a      <= '0;
      opr_b      <= '0;
      opr_op     <= '0;
      opr_tag    <= '0;
      out_valid  <= 1'b0;
      out_result <= '0;
      out_tag    <= '0;
      out_flags  <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (accept) begin
        opr_a   <= in_a;
        opr_b   <= in_b;
        opr_op  <= in_op;
        opr_tag <= in_tag;
      end
      if (capture) begin
        out_valid           <= 1'b1;
        out_result          <= sel_res;
        out_tag             <= opr_tag;
        out_flags[FLG_ILL]  <= res_ill;
        out_flags[FLG_NAN]  <= res_nan;
        out_flags[FLG_INF]  <= res_inf;
        out_flags[FLG_ZERO] <= res_zero;
      end else if (drop) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fpu_seq_unit.sv
// Scenario bench for fpu_seq_unit against a real-arithmetic reference model.
module tb_fpu_seq_unit;
  localparam int TAG_W   = 4;
  localparam int ADD_LAT = 2;
  localparam int MUL_LAT = 3;
  localparam int DIV_LAT = 8;
  localparam logic [63:0] SIGN_MASK = 64'h8000_0000_0000_0000;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [63:0]      in_a = '0;
  logic [63:0]      in_b = '0;
  logic [2:0]       in_op = '0;
  logic [TAG_W-1:0] in_tag = '0;
  logic             flush = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [63:0]      out_result;
  logic [TAG_W-1:0] out_tag;
  logic [3:0]       out_flags;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  fpu_seq_unit #(.TAG_W(TAG_W), .ADD_LAT(ADD_LAT), .MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_op(in_op), .in_tag(in_tag), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_tag(out_tag), .out_flags(out_flags)
  );

  function automatic int ref_lat(input logic [2:0] op);
    case (op)
      3'd0, 3'd1: return ADD_LAT;
      3'd2:       return MUL_LAT;
      3'd3:       return DIV_LAT;
      default:    return 1;
    endcase
  endfunction

  function automatic logic [63:0] ref_result(input logic [2:0] op, input logic [63:0] a,
                                             input logic [63:0] b);
    real ra, rb;
    ra = $bitstoreal(a);
    rb = $bitstoreal(b);
    case (op)
      3'd0:    return $realtobits(ra + rb);
      3'd1:    return $realtobits(ra - rb);
      3'd2:    return $realtobits(ra * rb);
      3'd3:    return $realtobits(ra / rb);
      3'd4:    return a ^ SIGN_MASK;
      3'd5:    return a & ~SIGN_MASK;
      default: return 64'd0;
    endcase
  endfunction

  function automatic logic [3:0] ref_flags(input logic [2:0] op, input logic [63:0] r);
    logic [10:0] ex;
    logic [51:0] man;
    ex  = r[62:52];
    man = r[51:0];
    return {op >= 3'd6, ex == 11'h7FF && man != 0, ex == 11'h7FF && man == 0,
            ex == 11'd0 && man == 0};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b,
                       input logic [TAG_W-1:0] tag);
    in_valid = 1'b1;
    in_op    = op;
    in_a     = a;
    in_b     = b;
    in_tag   = tag;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!out_valid && n < 40);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++; $display("FAIL reset_valid_in_reset: got %b want 0", out_valid);
    end
    #11 rst_n = 1'b1;
    tick();
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++; $display("FAIL reset_in_ready: got %b want 1", in_ready);
    end
    vectors++;
    if (out_valid !== 1'b0 || out_result !== 64'd0 || out_tag !== '0 || out_flags !== 4'd0) begin
      miscompares++;
      $display("FAIL reset_outputs: got v=%b r=%h t=%h f=%b want all 0",
               out_valid, out_result, out_tag, out_flags);
    end
  endtask

  task automatic test_add_basic();
    int n;
    issue(3'd0, 64'h3FF0_0000_0000_0000, 64'h4000_0000_0000_0000, 4'd5);
    wait_valid(n);
    vectors++;
    if (n !== ADD_LAT) begin miscompares++; $display("FAIL add_latency: got %0d want %0d", n, ADD_LAT); end
    vectors++;
    if (out_result !== 64'h4008_0000_0000_0000) begin
      miscompares++; $display("FAIL add_result: got %h want 4008000000000000", out_result);
    end
    vectors++;
    if (out_tag !== 4'd5 || out_flags !== 4'b0000) begin
      miscompares++; $display("FAIL add_tag_flags: got %h/%b want 5/0000", out_tag, out_flags);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    vectors++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      miscompares++; $display("FAIL add_retire: got v=%b rdy=%b want 0/1", out_valid, in_ready);
    end
  endtask

  task automatic test_div_zero();
    int n;
    issue(3'd3, 64'h3FF0_0000_0000_0000, 64'd0, 4'd11);
    wait_valid(n);
    vectors++;
    if (n !== DIV_LAT) begin miscompares++; $display("FAIL div0_latency: got %0d want %0d", n, DIV_LAT); end
    vectors++;
    if (out_result !== 64'h7FF0_0000_0000_0000 || out_flags !== 4'b0010) begin
      miscompares++;
      $display("FAIL div0_result: got %h/%b want 7ff0000000000000/0010", out_result, out_flags);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    issue(3'd4, 64'h4000_0000_0000_0000, 64'd0, 4'd1);
    vectors++;
    if (out_valid !== 1'b0) begin miscompares++; $display("FAIL b2b_early_valid: got %b want 0", out_valid); end
    tick();
    vectors++;
    if (out_valid !== 1'b1 || out_result !== 64'hC000_0000_0000_0000 || out_tag !== 4'd1) begin
      miscompares++;
      $display("FAIL b2b_neg: got v=%b r=%h t=%h want 1/c000000000000000/1", out_valid, out_result, out_tag);
    end
    vectors++;
    if (in_ready !== 1'b1) begin miscompares++; $display("FAIL b2b_no_bubble: got in_ready=%b want 1", in_ready); end
    issue(3'd5, 64'hC000_0000_0000_0000, 64'd0, 4'd2);
    vectors++;
    if (out_valid !== 1'b0) begin miscompares++; $display("FAIL b2b_retired: got %b want 0", out_valid); end
    tick();
    vectors++;
    if (out_valid !== 1'b1 || out_result !== 64'h4000_0000_0000_0000 || out_tag !== 4'd2) begin
      miscompares++;
      $display("FAIL b2b_abs: got v=%b r=%h t=%h want 1/4000000000000000/2", out_valid, out_result, out_tag);
    end
    tick();
    out_ready = 1'b0;
    vectors++;
    if (out_valid !== 1'b0) begin miscompares++; $display("FAIL b2b_drain: got %b want 0", out_valid); end
  endtask

  task automatic test_illegal_stall();
    int n;
    issue(3'd6, 64'h1234_5678_9ABC_DEF0, 64'h1, 4'd9);
    wait_valid(n);
    vectors++;
    if (n !== 1) begin miscompares++; $display("FAIL ill_latency: got %0d want 1", n); end
    in_valid = 1'b1;
    in_op    = 3'd0;
    in_tag   = 4'd7;
    for (int s = 0; s < 5; s++) begin
      vectors++;
      if (out_valid !== 1'b1 || out_result !== 64'd0 || out_tag !== 4'd9 || out_flags !== 4'b1001) begin
        miscompares++;
        $display("FAIL ill_hold[%0d]: got v=%b r=%h t=%h f=%b want 1/0/9/1001",
                 s, out_valid, out_result, out_tag, out_flags);
      end
      vectors++;
      if (in_ready !== 1'b0) begin miscompares++; $display("FAIL ill_stall_ready[%0d]: got %b want 0", s, in_ready); end
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    #1;
    vectors++;
    if (in_ready !== 1'b1) begin miscompares++; $display("FAIL ill_release_ready: got %b want 1", in_ready); end
    tick();
    out_ready = 1'b0;
    vectors++;
    if (out_valid !== 1'b0) begin miscompares++; $display("FAIL ill_retire: got %b want 0", out_valid); end
  endtask

  task automatic test_flush();
    int  n;
    bit  seen;
    issue(3'd2, $realtobits(3.0), $realtobits(4.0), 4'd3);
    flush = 1'b1;
    #1;
    vectors++;
    if (in_ready !== 1'b0) begin miscompares++; $display("FAIL flush_forces_ready: got %b want 0", in_ready); end
    tick();
    flush = 1'b0;
    #1;
    vectors++;
    if (in_ready !== 1'b1) begin miscompares++; $display("FAIL flush_ready_after: got %b want 1", in_ready); end
    seen = 1'b0;
    for (int s = 0; s < 10; s++) begin
      if (out_valid) seen = 1'b1;
      tick();
    end
    vectors++;
    if (seen !== 1'b0) begin miscompares++; $display("FAIL flush_no_result: got out_valid seen=%b want 0", seen); end
    issue(3'd0, $realtobits(2.5), $realtobits(4.25), 4'd4);
    wait_valid(n);
    vectors++;
    if (n !== ADD_LAT || out_result !== $realtobits(6.75) || out_tag !== 4'd4) begin
      miscompares++;
      $display("FAIL flush_next_add: got lat=%0d r=%h t=%h want %0d/%h/4", n, out_result, out_tag,
               ADD_LAT, $realtobits(6.75));
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset_midop();
    bit seen;
    issue(3'd3, $realtobits(6.0), $realtobits(3.0), 4'd6);
    tick();
    tick();
    tick();
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if (out_valid !== 1'b0 || out_result !== 64'd0 || out_tag !== '0 || out_flags !== 4'd0) begin
      miscompares++;
      $display("FAIL rst_midop_async: got v=%b r=%h t=%h f=%b want all 0",
               out_valid, out_result, out_tag, out_flags);
    end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int s = 0; s < 12; s++) begin
      tick();
      if (out_valid) seen = 1'b1;
    end
    vectors++;
    if (seen !== 1'b0 || in_ready !== 1'b1) begin
      miscompares++; $display("FAIL rst_midop_stale: got seen=%b rdy=%b want 0/1", seen, in_ready);
    end
  endtask

  task automatic test_random(input int iters);
    logic [2:0]       op;
    logic [63:0]      a, b, er;
    logic [3:0]       ef;
    logic [TAG_W-1:0] tag;
    int               n, x, y, k, stall;
    for (int it = 0; it < iters; it++) begin
      op  = 3'($urandom_range(0, 7));
      tag = TAG_W'($urandom);
      x   = int'($urandom_range(0, 80)) - 40;
      y   = int'($urandom_range(0, 80)) - 40;
      if (op == 3'd3) begin
        y = int'($urandom_range(1, 8)) * (($urandom_range(0, 1) == 1) ? -1 : 1);
        k = int'($urandom_range(0, 20)) - 10;
        x = y * k;
      end
      if (op >= 3'd4) a = {$urandom, $urandom};
      else            a = $realtobits(real'(x));
      b  = $realtobits(real'(y));
      er = ref_result(op, a, b);
      ef = ref_flags(op, er);
      issue(op, a, b, tag);
      wait_valid(n);
      vectors++;
      if (n !== ref_lat(op)) begin
        miscompares++; $display("FAIL rnd_latency[%0d] op=%0d: got %0d want %0d", it, op, n, ref_lat(op));
      end
      stall = int'($urandom_range(0, 3));
      for (int s = 0; s < stall; s++) begin
        tick();
        vectors++;
        if (out_valid !== 1'b1 || out_tag !== tag) begin
          miscompares++; $display("FAIL rnd_stall[%0d]: got v=%b t=%h want 1/%h", it, out_valid, out_tag, tag);
        end
      end
      vectors++;
      if (out_result !== er || out_tag !== tag || out_flags !== ef) begin
        miscompares++;
        $display("FAIL rnd_result[%0d] op=%0d a=%h b=%h: got %h/%h/%b want %h/%h/%b",
                 it, op, a, b, out_result, out_tag, out_flags, er, tag, ef);
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      vectors++;
      if (out_valid !== 1'b0) begin miscompares++; $display("FAIL rnd_retire[%0d]: got %b want 0", it, out_valid); end
    end
  endtask

  initial begin
    test_reset();
    test_add_basic();
    test_div_zero();
    test_back_to_back();
    test_illegal_stall();
    test_flush();
    test_reset_midop();
    test_random(40);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "time limit");
  end

endmodule
